muldiv: RTL and testbench
=========================

# muldiv

Iterative RV32M/RV64M multiply/divide unit. It sits beside the single-cycle ALU in the execute stage and takes the same operand pair with funct3 as the operation select. Operations run over multiple cycles behind a valid/ready handshake. XLEN is parametrised, and the unit adds signed/unsigned high-product, division and remainder behaviour that the combinational ALU lacks.

## Interface
- XLEN, 32, operand and result width; power of two, ≥ 8
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous reset, active-low
- flush  in  1  abort any in-flight operation (pipeline kill)
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept (state IDLE and reset_n high)
- a  in  XLEN  rs1 operand
- b  in  XLEN  rs2 operand
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  operation result, stable while out_valid

## Operation
- States: IDLE, BUSY, DONE. in_ready=1 only in IDLE (0 while reset_n low). out_valid=1 only in DONE.
- Accept: an edge with in_valid && in_ready. a, b and op are latched; inputs may change afterwards.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Signed operands are converted to magnitudes at accept; the result sign is fixed on the final iteration.
- Multiply: shift-add over XLEN iterations into a 2·XLEN product.
  - Negate the product if the operand signs differ.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2·XLEN-1:XLEN].
- Divide: restoring, one quotient bit per iteration, XLEN iterations.
  - Quotient sign = sign(a) ^ sign(b) (DIV only).
  - Remainder sign = sign(a) (REM only).
- Special cases, decided at accept (skip BUSY, go straight to DONE):
  - b == 0: DIV/DIVU give all ones; REM/REMU give a.
  - Signed overflow, DIV with a = most-negative and b = −1: quotient = a, REM = 0.
- BUSY: an iteration counter of width $clog2(XLEN) starts at 0 and increments once per edge. On the edge where counter == XLEN−1, the final iteration and sign fix complete and the state goes to DONE.
- DONE: result is held. An edge with out_ready goes to IDLE. No accept can happen in the same cycle, because in_ready is low in DONE.
- flush (any state, reset_n high): next edge goes to IDLE, out_valid drops, and the result is discarded. flush on the accept edge cancels that accept.
- Priority: reset_n > flush > handshake.
- Reset values: state IDLE, out_valid 0, result 0, counter 0, all internal operand/accumulator registers 0.

## Timing
- Normal operation: accept at edge 0, out_valid high after edge XLEN (XLEN cycles of latency).
- Special case: out_valid high after edge 1.
- Minimum initiation interval: XLEN+2 cycles (accept → DONE → IDLE → next accept).
- result and out_valid are registered; in_ready is decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- Back-pressure: DONE persists indefinitely while out_ready is low; result does not change.
- reset_n low mid-operation: IDLE on the next edge and out_valid 0. No stale result appears after reset is released.

## Test plan
- Latency and sign, XLEN=32: MUL a=7, b=0xFFFFFFFD (−3) → result 0xFFFFFFEB; out_valid exactly 32 cycles after accept; in_ready low throughout.
- High products:
  - MULH 0x80000000×0x80000000 → 0x40000000
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF
- Division rounds toward zero:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF
  - DIVU 100/7 → 14; REMU 100/7 → 2
- Special cases, out_valid 1 cycle after accept:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0
- Back-pressure: complete a DIVU, hold out_ready low for 5 cycles.
  - result stays constant, in_ready stays 0.
  - Raise out_ready: in_ready = 1 on the next cycle; the next accept gives correct results.
- Abort:
  - flush pulsed 10 cycles into a MUL → no out_valid ever; in_ready = 1 the next cycle.
  - reset_n low 10 cycles into a DIV → out_valid 0 and result 0; after release, a new MUL 3×4 returns 12.

Source files
------------

// File: rtl/muldiv.sv
// muldiv: iterative RV32M/RV64M multiply/divide unit with valid/ready handshake.
module muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] op_r;
  logic neg, sa, sb, zero, ovf, special;
  logic [XLEN-1:0] hi, lo, m, mag_a, mag_b, spec_res, nhi, nlo, fin;
  logic [XLEN:0] add, rsh, diff;
  logic [2*XLEN-1:0] prod;
  assign in_ready = (state == IDLE) && reset_n;
  // hi/lo hold the product (multiply) or remainder/quotient (divide); m is the fixed operand
  always_comb begin
    sa = a[XLEN-1] & (op[2] ? ~op[0] : (op[1:0] != 2'b11));
    sb = b[XLEN-1] & (op[2] ? ~op[0] : ~op[1]);
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;
    zero = b == '0;
    ovf = ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
    special = op[2] & (zero | ovf);
    spec_res = zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
    add = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    rsh = {hi, lo[XLEN-1]};
    diff = rsh - {1'b0, m};
    nhi = op_r[2] ? (diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0]) : add[XLEN:1];
    nlo = op_r[2] ? {lo[XLEN-2:0], ~diff[XLEN]} : {add[0], lo[XLEN-1:1]};
    prod = neg ? -{nhi, nlo} : {nhi, nlo};
    fin = op_r[2] ? (op_r[1] ? (neg ? -nhi : nhi) : (neg ? -nlo : nlo))
                  : (op_r[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      op_r <= '0;
      neg <= 1'b0;
      hi <= '0;
      lo <= '0;
      m <= '0;
      result <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      cnt <= '0;
      out_valid <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      op_r <= op;
      neg <= (op[2] & op[1]) ? sa : sa ^ sb;
      hi <= '0;
      lo <= op[2] ? mag_a : mag_b;
      m <= op[2] ? mag_b : mag_a;
      cnt <= '0;
      state <= special ? DONE : BUSY;
      out_valid <= special;
      if (special) result <= spec_res;
    end else if (state == BUSY) begin
      hi <= nhi;
      lo <= nlo;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(XLEN-1)) begin
        result <= fin;
        state <= DONE;
        out_valid <= 1'b1;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: random and directed checks of muldiv against an arithmetic reference model.
module tb_muldiv;
  localparam int X = 32;
  logic clk = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [X-1:0] a = '0, b = '0, result;
  logic [2:0] op = '0;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  muldiv #(.XLEN(X)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );
  function automatic logic [X-1:0] model(input logic [2:0] o, input logic [X-1:0] x, input logic [X-1:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = {32'd0, x};
    longint uy = {32'd0, y};
    logic [63:0] p;
    logic ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFF_FFFF : ov ? x : 32'(sx / sy);
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: return (y == 0) ? x : ov ? 32'd0 : 32'(sx % sy);
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction
  function automatic bit is_special(input logic [2:0] o, input logic [X-1:0] x, input logic [X-1:0] y);
    return o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction
  task automatic chk(input string name, input logic [X-1:0] got, input logic [X-1:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask
  // Behavioural timing model: one request in flight, result due a fixed number of cycles later
  bit fl = 0, clean = 0, ov_exp;
  int cyc = 0, acc = 0, lat = 0;
  logic [X-1:0] exp_r;
  always @(negedge clk) begin
    cyc++;
    ov_exp = fl && (cyc - acc >= lat);
    chk("in_ready", in_ready, reset_n && !fl);
    chk("out_valid", out_valid, ov_exp);
    if (ov_exp) chk("result", result, exp_r);
    if (clean) chk("result_after_reset", result, 0);
    if (!reset_n) begin
      fl = 0;
      clean = 1;
    end else if (flush) fl = 0;
    else if (ov_exp && out_ready) fl = 0;
    else if (!fl && in_valid) begin
      fl = 1;
      clean = 0;
      exp_r = model(op, a, b);
      lat = is_special(op, a, b) ? 1 : X + 1;
      acc = cyc;
    end
  end
  task automatic send(input logic [2:0] o, input logic [X-1:0] x, input logic [X-1:0] y);
    int n = 0;
    op = o; a = x; b = y; in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 0; a = $urandom; b = $urandom; op = 3'($urandom);
  endtask
  task automatic recv(input int hold, output logic [X-1:0] r);
    int n = 0;
    r = 'x;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    if (!out_valid) chk("out_valid_wait", out_valid, 1);
    else begin
      r = result;
      @(posedge clk);
      repeat (hold) @(posedge clk);
      #1 out_ready = 1;
      @(posedge clk);
      #1 out_ready = 0;
    end
  endtask
  task automatic check_op(input logic [2:0] o, input logic [X-1:0] x, input logic [X-1:0] y, input logic [X-1:0] e);
    logic [X-1:0] r;
    chk("model_pin", model(o, x, y), e);
    send(o, x, y);
    recv(0, r);
    chk($sformatf("op%0d_%h_%h", o, x, y), r, e);
  endtask
  function automatic logic [X-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic [X-1:0] r;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    chk("reset_result", result, 0);
    chk("reset_out_valid", out_valid, 0);
    check_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    check_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    check_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    check_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    check_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    check_op(3'd5, 32'd100, 32'd7, 32'd14);
    check_op(3'd7, 32'd100, 32'd7, 32'd2);
    check_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    check_op(3'd7, 32'd5, 32'd0, 32'd5);
    check_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    check_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    send(3'd5, 32'd1000, 32'd9);
    recv(5, r);
    chk("backpressure_divu", r, 32'd111);
    check_op(3'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd6);
    send(3'd0, 32'd1234, 32'd5678);
    repeat (10) @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    chk("flush_in_ready", in_ready, 1);
    repeat (X + 5) @(posedge clk);
    #1 chk("flush_no_valid", out_valid, 0);
    op = 3'd5; a = 32'd9; b = 32'd3; in_valid = 1; flush = 1;
    @(posedge clk);
    #1 in_valid = 0; flush = 0;
    chk("flush_accept_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1 chk("flush_accept_no_valid", out_valid, 0);
    send(3'd4, 32'hFFFF_FF9C, 32'd7);
    repeat (10) @(posedge clk);
    #1 reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    chk("midop_reset_result", result, 0);
    chk("midop_reset_out_valid", out_valid, 0);
    check_op(3'd0, 32'd3, 32'd4, 32'd12);
    for (int i = 0; i < 300; i++) begin
      logic [2:0] o;
      logic [X-1:0] x, y;
      o = 3'($urandom);
      x = pick();
      y = pick();
      send(o, x, y);
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 40)) @(posedge clk);
        #1 flush = 1;
        @(posedge clk);
        #1 flush = 0;
      end else recv($urandom_range(0, 3), r);
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
